// File: rtl/seq_mult_arbiter_if.sv
// Request, response and multiplier-core signals of the shared multiplier arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// requesters, the response consumer and the core.
interface seq_mult_arbiter_if #(
  parameter int N    = 32,
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;

  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [2*N-1:0]    resp_product;

  logic              mult_start;
  logic [N-1:0]      mult_a;
  logic [N-1:0]      mult_b;
  logic              mult_done;
  logic [2*N-1:0]    mult_product;

  logic              err_timeout;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, mult_done, mult_product,
    output req_ready, resp_valid, resp_id, resp_product,
           mult_start, mult_a, mult_b, err_timeout
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready, mult_done, mult_product,
    input  req_ready, resp_valid, resp_id, resp_product,
           mult_start, mult_a, mult_b, err_timeout
  );
endinterface

// File: rtl/seq_mult_arbiter.sv
// Round-robin arbiter that shares one sequential multiplier core among NREQ requesters.
// It also runs a sticky watchdog that flags a core that never raises done.
module seq_mult_arbiter #(
  parameter int N       = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input logic                clk,
  input logic                reset,
  seq_mult_arbiter_if.slave  bus
);
  localparam int IDW  = $clog2(NREQ);
  localparam int CNTW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arbState;

  arbState        state, stateNext;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grantIdx, candIdx;
  logic           grantFound;
  logic [N-1:0]   grantA, grantB;
  logic [N-1:0]   opA, opB;
  logic [IDW-1:0] respId;
  logic [2*N-1:0] respProduct;
  logic           errTimeout;
  logic [CNTW-1:0] wdCnt;
  logic           timeoutHit;

  // Scan starts just past the last winner, so the last winner ranks lowest.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    candIdx    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      candIdx = IDW'((32'(ptr) + k) % 32'(NREQ));
      if (!grantFound && bus.req_valid[candIdx]) begin
        grantFound = 1'b1;
        grantIdx   = candIdx;
      end
    end
  end

  always_comb begin
    grantA = '0;
    grantB = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grantIdx == IDW'(i)) begin
        grantA = bus.req_a[i*N +: N];
        grantB = bus.req_b[i*N +: N];
      end
    end
  end

  assign timeoutHit = (wdCnt == CNTW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext      = state;
    bus.req_ready  = '0;
    bus.mult_start = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (grantFound) begin
          bus.req_ready[grantIdx] = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        bus.mult_start = 1'b1;
        stateNext      = WAIT;
      end
      WAIT: begin
        if (bus.mult_done || timeoutHit) stateNext = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // While reset is asserted, every handshake output reads 0.
    if (reset) begin
      bus.req_ready  = '0;
      bus.mult_start = 1'b0;
      bus.resp_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= IDW'(NREQ - 1);
      opA         <= '0;
      opB         <= '0;
      respId      <= '0;
      respProduct <= '0;
      errTimeout  <= 1'b0;
      wdCnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          wdCnt <= '0;
          if (grantFound) begin
            ptr    <= grantIdx;
            respId <= grantIdx;
            opA    <= grantA;
            opB    <= grantB;
          end
        end
        WAIT: begin
          // A done that arrives in the timeout cycle wins, and the flag is left alone.
          if (bus.mult_done) begin
            respProduct <= bus.mult_product;
            wdCnt       <= '0;
          end else if (timeoutHit) begin
            errTimeout  <= 1'b1;
            respProduct <= '0;
            wdCnt       <= '0;
          end else begin
            wdCnt <= wdCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mult_a       = opA;
  assign bus.mult_b       = opB;
  assign bus.resp_id      = respId;
  assign bus.resp_product = respProduct;
  assign bus.err_timeout  = errTimeout;
endmodule

// File: doc/seq_mult_arbiter.md
Name: seq_mult_arbiter

Overview:
- Round-robin scheduler that shares one sequential (multi-cycle) multiplier core among NREQ requesters.
- Accepts one operand pair at a time from the requesters and issues a start pulse to the core.
- Waits for the core's done, then returns the 2N-bit product tagged with the requester id over a valid/ready response channel.
- Sits between the operand-producing blocks and the shared multiplier core. Includes a watchdog that flags a core that never completes.

Parameters:
- N, 32, operand width; the product is 2N bits.
- NREQ, 4, number of requesters (at least 2). IDW = $clog2(NREQ) is derived from it.
- TIMEOUT, 64, maximum number of WAIT cycles before the error flag is set.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept. At most one bit is high per cycle.
- req_a  in  NREQ*N  operand A; requester i drives [i*N +: N].
- req_b  in  NREQ*N  operand B; same packing as req_a.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  IDW  index of the requester that owns the response.
- resp_product  out  2N  product {hi, lo}.
- mult_start  out  1  one-cycle start pulse to the core.
- mult_a  out  N  operand A to the core.
- mult_b  out  N  operand B to the core.
- mult_done  in  1  core completion strobe.
- mult_product  in  2N  core result; valid while mult_done=1.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
Reset (synchronous, active-high):
- State goes to IDLE.
- All outputs go to 0, including err_timeout.
- The round-robin pointer goes to NREQ-1, so requester 0 has the highest priority first.

State machine (IDLE, ISSUE, WAIT, RESP):
- IDLE, no request: if no bit of req_valid is set, stay in IDLE.
- IDLE, grant:
  - Pick the first set bit of req_valid, scanning from pointer+1 upward and wrapping modulo NREQ. Call it g.
  - req_ready[g]=1 combinationally in the same cycle. The handshake completes that cycle.
  - Latch req_a[g], req_b[g] and g. Set pointer to g. Go to ISSUE.
- ISSUE:
  - mult_start=1 for exactly one cycle.
  - mult_a and mult_b drive the latched operands; go to WAIT.
- WAIT:
  - mult_a and mult_b stay stable; the watchdog counter increments each cycle.
  - On mult_done=1: capture mult_product into resp_product, clear the counter, go to RESP.
  - If the counter reaches TIMEOUT without mult_done: set err_timeout (sticky until reset), load resp_product with 0, go to RESP. The requester is still answered.
- RESP:
  - resp_valid=1; resp_id and resp_product are held stable.
  - On resp_valid&&resp_ready: clear resp_valid and go to IDLE.
  - resp_valid must never drop without a handshake.

Timing:
- req_ready is 0 in every state except IDLE. A new grant happens no earlier than the cycle after the response handshake.
- Latency: request accepted in cycle T → mult_start in T+1 → mult_done in T+1+k (k ≥ 1) → resp_valid from T+2+k. The minimum handshake-to-handshake period is k+3 cycles.

Boundary conditions:
- mult_done outside WAIT is ignored. mult_done in the same cycle as the timeout wins: the product is captured and err_timeout stays unchanged.
- A requester that keeps req_valid high is served again only after every other pending requester has been served (fairness).
- A requester may drop req_valid before a grant without penalty. Operands only need to be valid in the grant cycle.
- Reset mid-operation (ISSUE/WAIT/RESP) drops the transaction with no response. The core is reset by the same reset.
- Products are unsigned; the full 2N bits are passed through unmodified.

Test Plan:
- Single request: requester 0 sends A=3, B=5; stub core with k=4 → req_ready[0] at T, mult_start at T+1, resp_valid at T+6, resp_id=0, resp_product=15.
- All requesters constantly valid, operands i+1 and 2: grants follow 0,1,2,3,0,1…; products 2,4,6,8.
- Back-pressure: hold resp_ready=0 for 10 cycles → resp_valid, resp_id and resp_product remain stable, req_ready stays 0 throughout, and the release completes one handshake.
- Max operands: A=B=0xFFFFFFFF → resp_product=0xFFFFFFFE00000001.
- Watchdog: stub core never asserts done → err_timeout=1 after 64 WAIT cycles, resp_valid with product 0. Later normal operations still work and err_timeout stays 1.
- Reset during WAIT, then a request from requester 2 → no stale response; requester 2 is granted (pointer restored to NREQ-1) and its product is correct.
